// File: rtl/load_store_unit.sv
// Load/store unit: byte/half/word accesses onto a word-wide memory, sub-word stores by read-modify-write.
// Latency load 2, word store 2, sub-word store 3, error 1; req_ready only in IDLE, no response back-pressure.
module load_store_unit #(
  parameter int ADDR_W = 8
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        req_valid,
  output logic        req_ready,
  input  logic        req_write,
  input  logic [1:0]  req_size,
  input  logic        req_unsigned,
  input  logic [31:0] req_addr,
  input  logic [31:0] req_wdata,
  output logic        resp_valid,
  output logic [31:0] resp_rdata,
  output logic        resp_error,
  output logic [31:0] mem_address,
  output logic [31:0] mem_write_data,
  output logic        mem_read,
  output logic        mem_write,
  input  logic [31:0] mem_read_data
);

  typedef enum logic [1:0] {IDLE, READ, WRITE, RESP} state_t;

  state_t            state, state_nxt;
  logic              write_q, uns_q, err_q;
  logic [1:0]        size_q;
  logic [ADDR_W+1:0] addr_q;
  logic [15:0]       wdata_q;
  logic [31:0]       wr_word_q, rdata_q;
  logic              accept, req_err;
  logic [7:0]        byte_sel;
  logic [15:0]       half_sel;
  logic [31:0]       load_val, merged;
  logic              unused_addr_hi;

  // Only the word-index bits reach the memory; the rest of the address is ignored.
  assign unused_addr_hi = ^req_addr[31:ADDR_W+2];

  assign accept  = (state == IDLE) && req_valid;
  assign req_err = (req_size == 2'b11) ||
                   ((req_size == 2'b01) && req_addr[0]) ||
                   ((req_size == 2'b10) && (req_addr[1:0] != 2'b00));

  always_comb begin
    state_nxt = state;
    case (state)
      IDLE: begin
        if (req_valid) begin
          if (req_err)                  state_nxt = RESP;
          else if (!req_write)          state_nxt = READ;
          else if (req_size == 2'b10)   state_nxt = WRITE;
          else                          state_nxt = READ;
        end
      end
      READ:    state_nxt = write_q ? WRITE : RESP;
      WRITE:   state_nxt = RESP;
      RESP:    state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) state <= IDLE;
    else       state <= state_nxt;
  end

  // Lane extraction for loads and lane insertion for sub-word stores.
  always_comb begin
    byte_sel = mem_read_data[{addr_q[1:0], 3'b000} +: 8];
    half_sel = mem_read_data[{addr_q[1], 4'b0000} +: 16];
    load_val = mem_read_data;
    merged   = mem_read_data;
    case (size_q)
      2'b00: begin
        load_val = uns_q ? {24'b0, byte_sel} : {{24{byte_sel[7]}}, byte_sel};
        merged[{addr_q[1:0], 3'b000} +: 8] = wdata_q[7:0];
      end
      2'b01: begin
        load_val = uns_q ? {16'b0, half_sel} : {{16{half_sel[15]}}, half_sel};
        merged[{addr_q[1], 4'b0000} +: 16] = wdata_q;
      end
      default: ;
    endcase
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      write_q   <= 1'b0;
      uns_q     <= 1'b0;
      err_q     <= 1'b0;
      size_q    <= 2'b00;
      addr_q    <= '0;
      wdata_q   <= '0;
      wr_word_q <= '0;
      rdata_q   <= '0;
    end else begin
      if (accept) begin
        write_q   <= req_write;
        uns_q     <= req_unsigned;
        err_q     <= req_err;
        size_q    <= req_size;
        addr_q    <= req_addr[ADDR_W+1:0];
        wdata_q   <= req_wdata[15:0];
        wr_word_q <= req_wdata;
      end
      if (state == READ) begin
        rdata_q   <= load_val;
        wr_word_q <= merged;
      end
    end
  end

  assign req_ready      = (state == IDLE);
  assign mem_read       = (state == READ);
  assign mem_write      = (state == WRITE);
  assign mem_address    = {{(32-ADDR_W){1'b0}}, addr_q[ADDR_W+1:2]};
  assign mem_write_data = (state == WRITE) ? wr_word_q : 32'h0;
  assign resp_valid     = (state == RESP);
  assign resp_error     = (state == RESP) && err_q;
  assign resp_rdata     = ((state == RESP) && !err_q && !write_q) ? rdata_q : 32'h0;

endmodule

// File: tb/tb_load_store_unit.sv
// Scoreboard bench for load_store_unit: random requests against a word-array reference model.
module tb_load_store_unit;
  localparam int AW = 8;

  logic        clk = 1'b0;
  logic        reset;
  logic        req_valid, req_ready, req_write, req_unsigned;
  logic [1:0]  req_size;
  logic [31:0] req_addr, req_wdata;
  logic        resp_valid, resp_error, mem_read, mem_write;
  logic [31:0] resp_rdata, mem_address, mem_write_data, mem_read_data;

  always #5 clk = ~clk;

  load_store_unit #(.ADDR_W(AW)) dut (
    .clk(clk), .reset(reset),
    .req_valid(req_valid), .req_ready(req_ready), .req_write(req_write),
    .req_size(req_size), .req_unsigned(req_unsigned), .req_addr(req_addr),
    .req_wdata(req_wdata), .resp_valid(resp_valid), .resp_rdata(resp_rdata),
    .resp_error(resp_error), .mem_address(mem_address), .mem_write_data(mem_write_data),
    .mem_read(mem_read), .mem_write(mem_write), .mem_read_data(mem_read_data)
  );

  logic [31:0] mem     [0:(1<<AW)-1];
  logic [31:0] ref_mem [0:(1<<AW)-1];

  assign mem_read_data = mem[mem_address[AW-1:0]];
  always @(posedge clk) if (mem_write) mem[mem_address[AW-1:0]] <= mem_write_data;

  typedef struct {
    logic [31:0] rdata;
    logic        err;
    int          lat;
    int          nrd;
    int          nwr;
    logic [31:0] wdat;
    logic [31:0] idx;
    int          acc;
  } exp_t;

  exp_t        sb[$];
  exp_t        cur;
  int          n_cmp = 0, n_fail = 0, cyc = 0, rd_cnt = 0, wr_cnt = 0;
  logic [31:0] last_rdata = 32'h0;

  always @(posedge clk) cyc <= cyc + 1;

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] expv);
    n_cmp++;
    if (act !== expv) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h (t=%0t)", nm, act, expv, $time);
    end
  endtask

  // Monitor: everything the DUT presents is checked against the head of the scoreboard.
  always @(negedge clk) begin
    if (!reset) begin
      chk("rd_wr_exclusive", {31'b0, mem_read & mem_write}, 32'h0);
      if (sb.size() == 0) begin
        chk("idle_ready", {31'b0, req_ready}, 32'h1);
        chk("spurious_resp", {31'b0, resp_valid}, 32'h0);
        chk("spurious_mem", {31'b0, mem_read | mem_write}, 32'h0);
      end else begin
        chk("busy_ready", {31'b0, req_ready}, 32'h0);
        if (mem_read) begin
          rd_cnt++;
          chk("rd_addr", mem_address, sb[0].idx);
        end
        if (mem_write) begin
          wr_cnt++;
          chk("wr_addr", mem_address, sb[0].idx);
          chk("wr_data", mem_write_data, sb[0].wdat);
        end
        if (resp_valid) begin
          cur = sb.pop_front();
          chk("resp_rdata", resp_rdata, cur.rdata);
          chk("resp_error", {31'b0, resp_error}, {31'b0, cur.err});
          chk("latency", cyc - cur.acc + 1, cur.lat);
          chk("n_reads", rd_cnt, cur.nrd);
          chk("n_writes", wr_cnt, cur.nwr);
          last_rdata = resp_rdata;
          rd_cnt = 0;
          wr_cnt = 0;
        end else begin
          chk("rdata_outside_resp", resp_rdata, 32'h0);
          chk("error_outside_resp", {31'b0, resp_error}, 32'h0);
        end
      end
    end
  end

  // Drive one request from a negedge; returns at the negedge after acceptance.
  task automatic issue(input logic w, input logic [1:0] sz, input logic u,
                       input logic [31:0] a, input logic [31:0] wd);
    exp_t        e;
    logic [63:0] word, val, lmask, smask;
    int          off, nb;
    bit          got;
    req_write = w; req_size = sz; req_unsigned = u; req_addr = a; req_wdata = wd;
    req_valid = 1'b1;
    got = 0;
    for (int i = 0; i < 40 && !got; i++) begin
      if (req_ready) got = 1;
      else @(negedge clk);
    end
    if (!got) begin
      chk("accept_timeout", 32'h0, 32'h1);
      req_valid = 1'b0;
      return;
    end
    off   = int'(a[1:0]);
    nb    = 1 << sz;
    lmask = (64'd1 << (8 * nb)) - 64'd1;
    e.idx = {{(32-AW){1'b0}}, a[AW+1:2]};
    e.err = (sz == 2'd3) || (sz == 2'd1 && a[0]) || (sz == 2'd2 && a[1:0] != 2'd0);
    e.rdata = 32'h0; e.nrd = 0; e.nwr = 0; e.wdat = 32'h0; e.lat = 1;
    if (!e.err && !w) begin
      word = 64'(ref_mem[e.idx]);
      val  = (word >> (8 * off)) & lmask;
      if (!u && nb < 4 && val[8*nb-1]) val = val | ~lmask;
      e.rdata = val[31:0]; e.lat = 2; e.nrd = 1;
    end else if (!e.err) begin
      smask  = lmask << (8 * off);
      word   = (64'(ref_mem[e.idx]) & ~smask) | ((64'(wd) << (8 * off)) & smask);
      e.wdat = word[31:0];
      e.lat  = (nb == 4) ? 2 : 3;
      e.nrd  = (nb == 4) ? 0 : 1;
      e.nwr  = 1;
    end
    e.acc = cyc + 1;
    @(posedge clk);
    sb.push_back(e);
    if (!e.err && w) ref_mem[e.idx] = e.wdat;
    @(negedge clk);
  endtask

  task automatic idle(input int n);
    req_valid = 1'b0;
    repeat (n) @(negedge clk);
  endtask

  logic [31:0] saved, rw;
  bit          drained;

  initial begin
    reset = 1'b0;
    req_valid = 1'b0; req_write = 1'b0; req_size = 2'b00; req_unsigned = 1'b0;
    req_addr = 32'h0; req_wdata = 32'h0;
    for (int i = 0; i < (1 << AW); i++) begin
      rw = $urandom;
      mem[i] = rw;
      ref_mem[i] = rw;
    end
    #1 reset = 1'b1;
    #2;
    chk("rst_req_ready", {31'b0, req_ready}, 32'h1);
    chk("rst_resp_valid", {31'b0, resp_valid}, 32'h0);
    chk("rst_resp_error", {31'b0, resp_error}, 32'h0);
    chk("rst_resp_rdata", resp_rdata, 32'h0);
    chk("rst_mem_rd_wr", {30'b0, mem_read, mem_write}, 32'h0);
    chk("rst_mem_address", mem_address, 32'h0);
    chk("rst_mem_wdata", mem_write_data, 32'h0);
    @(negedge clk); @(negedge clk);
    reset = 1'b0;
    @(negedge clk);

    // Worked examples, issued back to back where req_valid can stay high.
    issue(1'b1, 2'b10, 1'b0, 32'h10, 32'hDEADBEEF);
    idle(4);
    chk("word_store_mem", mem[4], 32'hDEADBEEF);
    issue(1'b1, 2'b00, 1'b0, 32'h11, 32'h00000055);
    idle(5);
    chk("byte_store_mem", mem[4], 32'hDEAD55EF);
    issue(1'b1, 2'b00, 1'b0, 32'h11, 32'hFFFFFF80);
    idle(5);
    chk("byte_store_mem2", mem[4], 32'hDEAD80EF);
    issue(1'b0, 2'b00, 1'b0, 32'h11, 32'h0);
    idle(4);
    chk("lb_signed", last_rdata, 32'hFFFFFF80);
    issue(1'b0, 2'b00, 1'b1, 32'h11, 32'h0);
    idle(4);
    chk("lb_unsigned", last_rdata, 32'h00000080);
    issue(1'b0, 2'b01, 1'b0, 32'h12, 32'h0);
    idle(4);
    chk("lh_signed", last_rdata, 32'hFFFFDEAD);
    issue(1'b0, 2'b01, 1'b0, 32'h13, 32'h0);
    issue(1'b0, 2'b10, 1'b0, 32'h12, 32'h0);
    issue(1'b0, 2'b11, 1'b0, 32'h10, 32'h0);
    issue(1'b1, 2'b10, 1'b0, 32'h20, 32'h12345678);
    issue(1'b0, 2'b10, 1'b1, 32'h20, 32'h0);
    idle(4);
    chk("lw_ignores_unsigned", last_rdata, 32'h12345678);

    // Reset in the WRITE cycle of a byte store must leave memory untouched.
    saved = ref_mem[8];
    issue(1'b1, 2'b00, 1'b0, 32'h21, 32'h000000A5);
    @(negedge clk);
    chk("mid_wr_before", {31'b0, mem_write}, 32'h1);
    #2 reset = 1'b1;
    req_valid = 1'b0;
    #1;
    chk("mid_wr_drop", {31'b0, mem_write}, 32'h0);
    chk("mid_wr_ready", {31'b0, req_ready}, 32'h1);
    chk("mid_wr_no_resp", {31'b0, resp_valid}, 32'h0);
    chk("mid_wr_addr", mem_address, 32'h0);
    sb.delete();
    rd_cnt = 0;
    wr_cnt = 0;
    ref_mem[8] = saved;
    @(posedge clk);
    @(negedge clk);
    reset = 1'b0;
    chk("mid_wr_mem", mem[8], saved);
    idle(3);

    // Random traffic over a small window of words so stores and loads interact.
    for (int n = 0; n < 400; n++) begin
      logic [31:0] a;
      a = {22'b0, 4'($urandom_range(0, 15)), 4'b0} >> 2;
      a = {22'b0, 6'(a[5:0]), 2'($urandom_range(0, 3)), 2'b00} >> 2;
      a = {24'b0, 2'b00, 4'($urandom_range(0, 15)), 2'($urandom_range(0, 3))};
      issue(1'($urandom), 2'($urandom_range(0, 3)), 1'($urandom), a, $urandom);
      if ($urandom_range(0, 2) == 0) idle($urandom_range(1, 3));
    end
    idle(1);
    drained = 0;
    for (int i = 0; i < 20 && !drained; i++) begin
      if (sb.size() == 0) drained = 1;
      else @(negedge clk);
    end
    if (!drained) chk("drain_timeout", 32'h0, 32'h1);
    for (int i = 0; i < (1 << AW); i++) chk("final_mem", mem[i], ref_mem[i]);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

  initial begin
    #2000000;
    $display("FAIL global_timeout: got running expected finished");
    $fatal(1, "timeout");
  end

endmodule
